// File: rtl/barrett_param_gen.sv
// Barrett constant generator: k = ceil(log2 q), mu = floor(2^(2k)/q) via leading-one detect + restoring divide.
// Optional macro BARRETT_REM_OUT_EN adds rem_o = 2^(2k) mod q.
module barrett_param_gen #(
  parameter int Q_W = 64,
  parameter int K_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [Q_W-1:0] q,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [K_W-1:0] k,
`ifdef BARRETT_REM_OUT_EN
  output logic [Q_W-1:0] rem_o,
`endif
  output logic [Q_W:0]   mu
);

  localparam int MU_W  = Q_W + 1;
  localparam int CNT_W = K_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t            state_reg;
  logic [Q_W-1:0]    q_reg;
  logic [Q_W:0]      rem_reg;
  logic [MU_W-1:0]   quo_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              first_reg;
  logic [K_W-1:0]    kcalc_reg;
  logic              errflag_reg;

  logic [K_W-1:0]    lod_p;
  logic              q_pow2;
  logic [K_W-1:0]    k_calc;
  logic [Q_W:0]      rem_sh;
  logic              rem_ge;

  // Leading-one detect: last set bit scanned upward wins.
  always_comb begin
    lod_p = '0;
    for (int i = 0; i < Q_W; i++) begin
      if (q_reg[i]) lod_p = K_W'(i);
    end
  end

  assign q_pow2 = ((q_reg & (q_reg - Q_W'(1))) == '0);
  assign k_calc = q_pow2 ? lod_p : lod_p + K_W'(1);

  // Dividend stream is a single 1 followed by zeros; first_reg supplies that leading 1.
  assign rem_sh = {rem_reg[Q_W-1:0], first_reg};
  assign rem_ge = ({rem_reg, first_reg} >= {2'b00, q_reg});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      q_reg       <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      cnt_reg     <= '0;
      first_reg   <= 1'b0;
      kcalc_reg   <= '0;
      errflag_reg <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      k           <= '0;
      mu          <= '0;
`ifdef BARRETT_REM_OUT_EN
      rem_o       <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            q_reg     <= q;
            busy      <= 1'b1;
            state_reg <= NORM;
          end
        end

        NORM: begin
          rem_reg   <= '0;
          quo_reg   <= '0;
          first_reg <= 1'b1;
          if (q_reg == '0) begin
            errflag_reg <= 1'b1;
            kcalc_reg   <= '0;
            cnt_reg     <= '0;
            state_reg   <= FIN;
          end else begin
            errflag_reg <= 1'b0;
            kcalc_reg   <= k_calc;
            cnt_reg     <= {k_calc, 1'b1};
            state_reg   <= DIV;
          end
        end

        DIV: begin
          // Restoring step; remainder stays below q so the top bit never survives.
          rem_reg   <= rem_ge ? (rem_sh - {1'b0, q_reg}) : rem_sh;
          quo_reg   <= {quo_reg[MU_W-2:0], rem_ge};
          first_reg <= 1'b0;
          cnt_reg   <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) state_reg <= FIN;
        end

        FIN: begin
          k         <= kcalc_reg;
          mu        <= quo_reg;
          err       <= errflag_reg;
`ifdef BARRETT_REM_OUT_EN
          rem_o     <= errflag_reg ? '0 : rem_reg[Q_W-1:0];
`endif
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrett_param_gen.sv
// Scoreboard bench for barrett_param_gen: arithmetic reference model, decoupled done monitor.
module tb_barrett_param_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] q = '0;
  logic        busy, done, err;
  logic [7:0]  k;
  logic [64:0] mu;
`ifdef BARRETT_REM_OUT_EN
  logic [63:0] rem_o;
`endif

  barrett_param_gen #(.Q_W(64), .K_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .k     (k),
`ifdef BARRETT_REM_OUT_EN
    .rem_o (rem_o),
`endif
    .mu    (mu)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] qv;
    logic [7:0]  k;
    logic [64:0] mu;
    logic        err;
    logic [63:0] rem;
    int          due;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  always @(posedge clk) cycle++;

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: smallest k with 2^k >= q, then plain wide division of 2^(2k).
  function automatic exp_t model(input logic [63:0] qv);
    exp_t e;
    logic [128:0] num;
    int kk;
    e.qv = qv;
    if (qv == 64'd0) begin
      e.k = 8'd0; e.mu = '0; e.err = 1'b1; e.rem = '0; e.due = 2;
    end else begin
      kk = 0;
      while ((129'(1) << kk) < 129'(qv)) kk++;
      num   = 129'(1) << (2 * kk);
      e.k   = 8'(kk);
      e.mu  = 65'(num / 129'(qv));
      e.rem = 64'(num % 129'(qv));
      e.err = 1'b0;
      e.due = 2 * kk + 3;
    end
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending request");
      end else begin
        e = sb.pop_front();
        $display("txn q=%h k=%0d mu=%h err=%b at cycle %0d", e.qv, k, mu, err, cycle);
        chk("k", 129'(k), 129'(e.k));
        chk("mu", 129'(mu), 129'(e.mu));
        chk("err", 129'(err), 129'(e.err));
        chk("latency", 129'(cycle), 129'(e.due));
        chk("busy_at_done", 129'(busy), 129'(0));
`ifdef BARRETT_REM_OUT_EN
        chk("rem_o", 129'(rem_o), 129'(e.rem));
`endif
      end
    end
  end

  task automatic issue(input logic [63:0] qv);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    q     = qv;
    @(posedge clk);
    #1;
    e = model(qv);
    e.due += cycle;
    sb.push_back(e);
    chk("busy_after_accept", 129'(busy), 129'(1));
    @(negedge clk);
    start = 1'b0;
    q     = {$urandom(), $urandom()};
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout: got %0d pending results expected 0", sb.size());
    sb.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 129'(busy), 129'(0));
    chk({tag, "_done"}, 129'(done), 129'(0));
    chk({tag, "_err"},  129'(err),  129'(0));
    chk({tag, "_k"},    129'(k),    129'(0));
    chk({tag, "_mu"},   129'(mu),   129'(0));
`ifdef BARRETT_REM_OUT_EN
    chk({tag, "_rem_o"}, 129'(rem_o), 129'(0));
`endif
  endtask

  logic [63:0] dir_q [6];
  initial begin
    logic [63:0] rq;
    dir_q[0] = 64'd17;
    dir_q[1] = 64'd16;
    dir_q[2] = 64'd1;
    dir_q[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    dir_q[4] = 64'd0;
    dir_q[5] = 64'd3;

    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      issue(dir_q[i]);
      drain();
    end

    // Start pulsed mid-run with a different q must be ignored.
    issue(64'd17);
    repeat (4) @(negedge clk);
    start = 1'b1;
    q     = 64'd5;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Asynchronous reset mid-run: outputs clear at once, the run yields no done.
    issue(64'd17);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrun_reset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(64'd5);
    drain();

    for (int i = 0; i < 20; i++) begin
      rq = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) rq = 64'd0;
      issue(rq);
      drain();
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
